// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: line geometry, address fields and the
// refill FSM encoding, so the cache and the refill engine agree on line layout.
package icache_pkg;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int LINE_BYTES = LINE_WORDS * (WORD_W / 8);
  localparam int CNT_W      = 2;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 4;
  localparam int OFF_MSB = 3;
  localparam int OFF_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } refill_state_e;

  // Word slot i of a line sits at this bit offset: word 0 is the top word.
  function automatic int slot_lsb(input int idx);
    return LINE_W - WORD_W * (idx + 1);
  endfunction
endpackage

// File: rtl/refill_line_buf.sv
// Four-word line assembly buffer with indexed write. line_next_o already
// includes the word being written this cycle, so the final word can be merged.
module refill_line_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [LINE_W-1:0] line_next_o
);
  logic [WORD_W-1:0] slot_q [LINE_WORDS];
  logic [WORD_W-1:0] slot_d [LINE_WORDS];

  always_comb begin
    slot_d = slot_q;
    if (we_i) slot_d[idx_i] = wdata_i;
    line_next_o = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_next_o[slot_lsb(i) +: WORD_W] = slot_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end
endmodule

// File: rtl/icache_refill.sv
// Instruction-cache line-fill engine: fetches the four words of a missing line
// in order over req/ack and delivers the whole line with a one-cycle strobe.
module icache_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                miss_ready,
  input  logic                abort,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                line_valid,
  output logic [ADDR_W-1:0]   line_addr,
  output logic [LINE_W-1:0]   dataline,
  output logic                busy,
  output refill_state_e       dbg_state
);
  // Handshakes: a miss is taken on an edge with miss_valid & miss_ready; a word
  // is taken on an edge with mem_req & mem_ack; line_valid is a bare strobe.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_WORDS - 1);

  refill_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              line_valid_q, line_valid_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [LINE_W-1:0] dataline_q, dataline_d;
  logic              word_we;
  logic [LINE_W-1:0] line_next;

  refill_line_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .we_i        (word_we),
    .idx_i       (cnt_q),
    .wdata_i     (mem_rdata),
    .line_next_o (line_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    mem_addr_d   = mem_addr_q;
    line_valid_d = 1'b0;
    line_addr_d  = line_addr_q;
    dataline_d   = dataline_q;
    word_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          state_d    = ST_FETCH;
          cnt_d      = '0;
          base_d     = miss_addr & LINE_MASK;
          mem_addr_d = miss_addr & LINE_MASK;
        end
      end
      ST_FETCH: begin
        // Abort wins over a same-edge ack, so that word is dropped.
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (mem_ack) begin
          word_we = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d      = ST_DONE;
            line_valid_d = 1'b1;
            line_addr_d  = base_q;
            dataline_d   = line_next;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            mem_addr_d = base_q | ADDR_W'({cnt_q + 1'b1, 2'b00});
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
      line_addr_q  <= '0;
      dataline_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      line_addr_q  <= line_addr_d;
      dataline_q   <= dataline_d;
    end
  end

  assign miss_ready = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_FETCH);
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DONE);
  assign mem_addr   = mem_addr_q;
  assign line_valid = line_valid_q;
  assign line_addr  = line_addr_q;
  assign dataline   = dataline_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: a table of fills driven through a bench memory
// model, a line scoreboard, and hand sequences for abort and async reset.
module tb_icache_refill;
  import icache_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid, miss_ready, abort;
  logic [31:0]   miss_addr;
  logic          mem_req, mem_ack;
  logic [31:0]   mem_addr, mem_rdata;
  logic          line_valid, busy;
  logic [31:0]   line_addr;
  logic [127:0]  dataline;
  refill_state_e dbg_state;

  icache_refill dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .abort      (abort),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .line_valid (line_valid),
    .line_addr  (line_addr),
    .dataline   (dataline),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset-independent cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [127:0] last_line = '0;
  logic [159:0] exp_q[$];  // {line_addr, dataline}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest expected line.
  always @(negedge clk) begin
    if (rst === 1'b0 && line_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_line_valid", 128'(line_valid), 128'(0));
      end else begin
        logic [159:0] e;
        e = exp_q.pop_front();
        chk("line_addr", 128'(line_addr), 128'(e[159:128]));
        chk("dataline", dataline, e[127:0]);
        last_line = e[127:0];
      end
    end
  end

  // Driver: one full fill with w wait cycles before each ack.
  task automatic run_fill(input logic [31:0] addr, input logic [127:0] line, input int w,
                          input logic [31:0] exp_base, input bit hold, input logic [31:0] next_addr,
                          input bit abort_acc, output int acc_cyc);
    miss_valid = 1'b1;
    miss_addr  = addr;
    abort      = abort_acc;
    chk("miss_ready_idle", 128'(miss_ready), 128'(1));
    exp_q.push_back({exp_base, line});
    tick();
    acc_cyc = cyc;
    abort   = 1'b0;
    if (hold) miss_addr = next_addr;
    else miss_valid = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'(1));
    chk("miss_ready_busy", 128'(miss_ready), 128'(0));
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j <= w; j++) begin
        mem_ack   = (j == w);
        mem_rdata = (j == w) ? line[127-32*k -: 32] : $urandom;
        chk("mem_req", 128'(mem_req), 128'(1));
        chk("mem_addr", 128'(mem_addr), 128'(exp_base + 32'(4 * k)));
        chk("no_early_line_valid", 128'(line_valid), 128'(0));
        chk("dataline_held", dataline, last_line);
        tick();
      end
    end
    mem_ack = 1'b0;
    chk("line_valid_strobe", 128'(line_valid), 128'(1));
    tick();
    chk("line_valid_one_cycle", 128'(line_valid), 128'(0));
    chk("miss_ready_back", 128'(miss_ready), 128'(1));
    chk("busy_clear", 128'(busy), 128'(0));
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
    int           w;
    logic [31:0]  exp_base;
    bit           hold;       // keep miss_valid high with the next entry's address
    bit           abort_acc;  // abort asserted while idle on the accept edge
  } fill_t;

  fill_t tbl[7];
  int    acc[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; abort = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_miss_ready", 128'(miss_ready), 128'(1));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_line_valid", 128'(line_valid), 128'(0));
    chk("rst_line_addr", 128'(line_addr), 128'(0));
    chk("rst_dataline", dataline, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    tick();

    tbl[0] = '{32'h0000_0048, 128'h11111111_22222222_33333333_44444444, 0, 32'h0000_0040, 0, 0};
    tbl[1] = '{32'h0000_1230, {$urandom, $urandom, $urandom, $urandom}, 2, 32'h0000_1230, 0, 1};
    tbl[2] = '{32'h0000_0040, {$urandom, $urandom, $urandom, $urandom}, 1, 32'h0000_0040, 1, 0};
    tbl[3] = '{32'h0000_0080, {$urandom, $urandom, $urandom, $urandom}, 0, 32'h0000_0080, 0, 0};
    tbl[4] = '{32'h0000_0000, {$urandom, $urandom, $urandom, $urandom}, 0, 32'h0000_0000, 1, 0};
    tbl[5] = '{32'h0000_0010, {$urandom, $urandom, $urandom, $urandom}, 0, 32'h0000_0010, 0, 0};
    tbl[6] = '{32'hFFFF_FFFF, {$urandom, $urandom, $urandom, $urandom}, 3, 32'hFFFF_FFF0, 0, 0};

    for (int i = 0; i < 7; i++) begin
      run_fill(tbl[i].addr, tbl[i].line, tbl[i].w, tbl[i].exp_base, tbl[i].hold,
               (i < 6) ? tbl[i+1].addr : 32'h0, tbl[i].abort_acc, acc[i]);
      // A held request is taken on the edge after the IDLE return:
      // 4*(1+w) edges to the strobe, one to leave DONE, one to accept.
      if (i > 0 && tbl[i-1].hold)
        chk("accept_spacing", 128'(acc[i] - acc[i-1]), 128'(4 * (1 + tbl[i-1].w) + 2));
    end

    // Abort on the edge that acks word 2
    miss_valid = 1'b1; miss_addr = 32'h0000_2008;
    tick();
    miss_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = $urandom; abort = 1'b1;
    tick();
    mem_ack = 1'b0; abort = 1'b0;
    chk("abort_state", 128'(dbg_state), 128'(ST_IDLE));
    chk("abort_mem_req", 128'(mem_req), 128'(0));
    chk("abort_miss_ready", 128'(miss_ready), 128'(1));
    chk("abort_dataline", dataline, last_line);
    // Acks while not requesting must be ignored
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
    end
    mem_ack = 1'b0;
    chk("idle_ack_dataline", dataline, last_line);
    chk("idle_ack_state", 128'(dbg_state), 128'(ST_IDLE));
    begin
      int a;
      run_fill(32'h0000_3004, {$urandom, $urandom, $urandom, $urandom}, 0, 32'h0000_3000, 0, 0, 0, a);
    end

    // Async reset between edges after word 1
    miss_valid = 1'b1; miss_addr = 32'h0000_5000;
    tick();
    miss_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
    end
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 128'(dbg_state), 128'(ST_IDLE));
    chk("arst_miss_ready", 128'(miss_ready), 128'(1));
    chk("arst_mem_req", 128'(mem_req), 128'(0));
    chk("arst_mem_addr", 128'(mem_addr), 128'(0));
    chk("arst_line_valid", 128'(line_valid), 128'(0));
    chk("arst_line_addr", 128'(line_addr), 128'(0));
    chk("arst_dataline", dataline, 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    last_line = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
    end
    mem_ack = 1'b0;
    chk("post_reset_idle", 128'(dbg_state), 128'(ST_IDLE));
    begin
      int a;
      run_fill(32'h0000_6ABC, {$urandom, $urandom, $urandom, $urandom}, 1, 32'h0000_6AB0, 0, 0, 0, a);
    end

    tick();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
